// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: on-chip responder for an HD44780-style 8-bit LCD bus.
// Snoops bus write cycles, decodes instructions, keeps a 2x16 DDRAM shadow,
// answers read cycles and models the controller's busy timing.
// Optional feature macro: LCD_RESP_BUSY_MODEL_EN
//   defined   -> busy timing, BUSY/CLEAR wait states and err_busy are modelled.
//   undefined -> busy/err_busy stay 0; writes that arrive during a clear are
//                held one deep and executed when the clear finishes.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    output logic [7:0] rd_data,
    output logic       rd_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    input  logic [4:0] dbg_idx,
    output logic [7:0] dbg_char,
    output logic       err_busy,
    output logic       err_addr
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLEAR} state_t;

    // Address counter step with the two-line wrap: 0x0F<->0x40, 0x4F<->0x00.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h0F) return 7'h40;
            if (a == 7'h4F) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h4F;
        if (a == 7'h40) return 7'h0F;
        return a - 7'd1;
    endfunction

    // Bus snapshot layout: {EN, RS, RW, DATA[7:0]}.
    logic [10:0] s1_q, s2_q, s3_q;
    logic        fall_q;
    logic [9:0]  cmd_q;            // {RS, RW, DATA} of the last completed transfer
    logic [7:0]  rd_data_q;
    logic        rd_oe_q;

    state_t      state_q;
    logic [4:0]  clr_idx_q;
    logic [7:0]  ddram_q [32];
    logic [6:0]  ac_q;
    logic        id_q, disp_q, cur_q, blink_q, err_addr_q;
`ifdef LCD_RESP_BUSY_MODEL_EN
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_busy_q;
    logic          long_busy;
`else
    logic          q_valid_q;
    logic [8:0]    q_cmd_q;        // {RS, DATA} of the held write
`endif

    logic       use_queue, exec_en, fall_wr;
    logic       x_rs, x_rw;
    logic [7:0] x_data;
    logic [4:0] ac_idx;
    logic [6:0] ac_d;
    logic       id_d, disp_d, cur_d, blink_d;
    logic       wr_en, is_write, start_clear, addr_bad;

    assign ac_idx  = {ac_q[6], ac_q[3:0]};
    assign fall_wr = fall_q & ~cmd_q[8];
`ifdef LCD_RESP_BUSY_MODEL_EN
    assign use_queue = 1'b0;
`else
    assign use_queue = q_valid_q & (state_q == ST_IDLE);
`endif
    // Writes arriving during a clear never execute directly.
    assign exec_en = use_queue | (fall_q & (state_q != ST_CLEAR));
`ifdef LCD_RESP_BUSY_MODEL_EN
    assign x_rs   = cmd_q[9];
    assign x_rw   = cmd_q[8];
    assign x_data = cmd_q[7:0];
`else
    assign x_rs   = use_queue ? q_cmd_q[8] : cmd_q[9];
    assign x_rw   = use_queue ? 1'b0 : cmd_q[8];
    assign x_data = use_queue ? q_cmd_q[7:0] : cmd_q[7:0];
`endif

    // Synchronise the bus, detect the EN falling edge and build the read response.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
        if (!iRST_N) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            fall_q    <= 1'b0;
            cmd_q     <= '0;
            rd_data_q <= '0;
            rd_oe_q   <= 1'b0;
        end else begin
            s1_q      <= {LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            fall_q    <= s3_q[10] & ~s2_q[10];
            if (s3_q[10] && !s2_q[10]) cmd_q <= s3_q[9:0];
            rd_oe_q   <= s1_q[10] & s1_q[8];
            rd_data_q <= s1_q[9] ? ddram_q[ac_idx] : {busy, ac_q};
        end
    end

    // Decode the transfer being executed this cycle into next-state values.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        ac_d        = ac_q;
        id_d        = id_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        wr_en       = 1'b0;
        is_write    = 1'b0;
        start_clear = 1'b0;
        addr_bad    = 1'b0;
`ifdef LCD_RESP_BUSY_MODEL_EN
        long_busy   = 1'b0;
`endif
        if (exec_en && x_rw && x_rs) begin
            ac_d = ac_step(ac_q, id_q);
        end else if (exec_en && !x_rw) begin
            is_write = 1'b1;
            if (x_rs) begin
                wr_en = 1'b1;
                ac_d  = ac_step(ac_q, id_q);
            end else begin
                casez (x_data)
                    8'b1???????: begin
                        if (x_data[5:4] == 2'b00) ac_d = x_data[6:0];
                        else addr_bad = 1'b1;
                    end
                    8'b0001????: if (!x_data[3]) ac_d = ac_step(ac_q, x_data[2]);
                    8'b00001???: begin
                        disp_d  = x_data[2];
                        cur_d   = x_data[1];
                        blink_d = x_data[0];
                    end
                    8'b000001??: id_d = x_data[1];
                    8'b0000001?: begin
                        ac_d = '0;
`ifdef LCD_RESP_BUSY_MODEL_EN
                        long_busy = 1'b1;
`endif
                    end
                    8'b00000001: begin
                        ac_d        = '0;
                        id_d        = 1'b1;
                        start_clear = 1'b1;
                    end
                    default: ;  // CGRAM address, function set: accepted, no effect
                endcase
            end
        end
    end

    // Controller state, DDRAM shadow and IDLE/BUSY/CLEAR sequencing.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            clr_idx_q  <= '0;
            // NOTE: the shadow is a small register file with a defined power-up content, so it is reset.
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
            ac_q       <= '0;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blink_q    <= 1'b0;
            err_addr_q <= 1'b0;
`ifdef LCD_RESP_BUSY_MODEL_EN
            cnt_q      <= '0;
            err_busy_q <= 1'b0;
`else
            q_valid_q  <= 1'b0;
            q_cmd_q    <= '0;
`endif
        end else begin
            ac_q    <= ac_d;
            id_q    <= id_d;
            disp_q  <= disp_d;
            cur_q   <= cur_d;
            blink_q <= blink_d;
            if (wr_en) ddram_q[ac_idx] <= x_data;
            if (addr_bad) err_addr_q <= 1'b1;
`ifndef LCD_RESP_BUSY_MODEL_EN
            if (use_queue) begin
                q_valid_q <= fall_wr;
                q_cmd_q   <= {cmd_q[9], cmd_q[7:0]};
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_clear) begin
                        state_q   <= ST_CLEAR;
                        clr_idx_q <= '0;
                    end
`ifdef LCD_RESP_BUSY_MODEL_EN
                    else if (is_write) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= long_busy ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
                    end
`endif
                end
`ifdef LCD_RESP_BUSY_MODEL_EN
                ST_BUSY: begin
                    if (is_write) begin
                        err_busy_q <= 1'b1;
                        if (start_clear) begin
                            state_q   <= ST_CLEAR;
                            clr_idx_q <= '0;
                        end else begin
                            cnt_q <= long_busy ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
                        end
                    end else if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                ST_CLEAR: begin
                    ddram_q[clr_idx_q] <= 8'h20;
                    clr_idx_q          <= clr_idx_q + 5'd1;
`ifdef LCD_RESP_BUSY_MODEL_EN
                    if (fall_wr) err_busy_q <= 1'b1;
                    if (clr_idx_q == 5'd31) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CW'(CLEAR_CYCLES - 32);
                    end
`else
                    if (fall_wr && !q_valid_q) begin
                        q_valid_q <= 1'b1;
                        q_cmd_q   <= {cmd_q[9], cmd_q[7:0]};
                    end
                    if (clr_idx_q == 5'd31) state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LCD_RESP_BUSY_MODEL_EN
    assign busy     = (state_q != ST_IDLE);
    assign err_busy = err_busy_q;
`else
    assign busy     = 1'b0;
    assign err_busy = 1'b0;
`endif
    assign rd_data   = rd_data_q;
    assign rd_oe     = rd_oe_q;
    assign ac        = ac_q;
    assign disp_on   = disp_q;
    assign cursor_on = cur_q;
    assign blink_on  = blink_q;
    assign err_addr  = err_addr_q;
    assign dbg_char  = ddram_q[dbg_idx];

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: drives HD44780-style bus cycles into lcd_bus_responder,
// keeps expected read responses in a queue and checks display state directly.
module tb_lcd_bus_responder;
    localparam int BUSY_CYC  = 40;
    localparam int CLEAR_CYC = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data = '0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_oe, busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on;
    logic [4:0] dbg_idx = '0;
    logic [7:0] dbg_char;
    logic       err_busy, err_addr;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic rd_oe_prev = 1'b0;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY_CYC), .CLEAR_CYCLES(CLEAR_CYC)) dut (
        .iCLK(clk), .iRST_N(rst_n), .LCD_DATA(lcd_data), .LCD_RS(lcd_rs),
        .LCD_RW(lcd_rw), .LCD_EN(lcd_en), .rd_data(rd_data), .rd_oe(rd_oe),
        .busy(busy), .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .dbg_idx(dbg_idx), .dbg_char(dbg_char),
        .err_busy(err_busy), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every read response is compared with the oldest expected value.
    always @(negedge clk) begin
        if (rd_oe && !rd_oe_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: rd_data=%02h with no expected value", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL read_data: got %02h expected %02h", rd_data, e);
                end
            end
        end
        rd_oe_prev = rd_oe;
    end

    task automatic bus_write(input logic rs, input logic [7:0] d, input int post, input bit wait_idle);
        int n;
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d;
        repeat (2) @(negedge clk);
        lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
        repeat (post) @(negedge clk);
        if (wait_idle) begin
            n = 0;
            while (busy && n < 4 * CLEAR_CYC) begin
                @(negedge clk);
                n++;
            end
            if (busy) begin
                checks++; failures++;
                $display("FAIL busy_timeout: busy=%b still set after %0d cycles", busy, n);
            end
        end
    endtask

    task automatic bus_read(input logic rs, input logic [7:0] expected);
        exp_q.push_back(expected);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1;
        repeat (2) @(negedge clk);
        lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
        repeat (6) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_oe, busy, ac} !== 9'h000) begin
            failures++;
            $display("FAIL reset_ctrl: rd_oe/busy/ac=%03h expected 000", {rd_oe, busy, ac});
        end
        checks++;
        if ({disp_on, cursor_on, blink_on, err_busy, err_addr} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {disp_on, cursor_on, blink_on, err_busy, err_addr});
        end
        for (int i = 0; i < 32; i++) begin
            dbg_idx = 5'(i); #1;
            checks++;
            if (dbg_char !== 8'h20) begin
                failures++;
                $display("FAIL reset_ddram[%0d]: got %02h expected 20", i, dbg_char);
            end
        end
        bus_read(1'b0, 8'h00);
    endtask

    task automatic test_display();
        bus_write(1'b0, 8'h0F, 6, 1);
        bus_write(1'b0, 8'h80, 6, 1);
        bus_write(1'b1, 8'h48, 6, 1);
        bus_write(1'b1, 8'h49, 6, 1);
        checks++;
        if ({disp_on, cursor_on, blink_on} !== 3'b111) begin
            failures++;
            $display("FAIL display_ctrl: got %b expected 111", {disp_on, cursor_on, blink_on});
        end
        dbg_idx = 5'd0; #1;
        checks++;
        if (dbg_char !== 8'h48) begin failures++; $display("FAIL display_c0: got %02h expected 48", dbg_char); end
        dbg_idx = 5'd1; #1;
        checks++;
        if (dbg_char !== 8'h49) begin failures++; $display("FAIL display_c1: got %02h expected 49", dbg_char); end
        checks++;
        if (ac !== 7'h02) begin failures++; $display("FAIL display_ac: got %02h expected 02", ac); end
        checks++;
        if (err_busy !== 1'b0) begin failures++; $display("FAIL display_err_busy: got %b expected 0", err_busy); end
        bus_write(1'b0, 8'h80, 6, 1);
        bus_read(1'b1, 8'h48);
        bus_read(1'b1, 8'h49);
        bus_read(1'b0, 8'h02);
    endtask

    task automatic test_wrap();
        bus_write(1'b0, 8'hCF, 6, 1);
        bus_write(1'b1, 8'h41, 6, 1);
        bus_write(1'b1, 8'h42, 6, 1);
        dbg_idx = 5'd31; #1;
        checks++;
        if (dbg_char !== 8'h41) begin failures++; $display("FAIL wrap_c31: got %02h expected 41", dbg_char); end
        dbg_idx = 5'd0; #1;
        checks++;
        if (dbg_char !== 8'h42) begin failures++; $display("FAIL wrap_c0: got %02h expected 42", dbg_char); end
        checks++;
        if (ac !== 7'h01) begin failures++; $display("FAIL wrap_ac: got %02h expected 01", ac); end
    endtask

    task automatic test_decrement();
        bus_write(1'b0, 8'h04, 6, 1);
        bus_write(1'b0, 8'h80, 6, 1);
        bus_write(1'b1, 8'h5A, 6, 1);
        dbg_idx = 5'd0; #1;
        checks++;
        if (dbg_char !== 8'h5A) begin failures++; $display("FAIL dec_c0: got %02h expected 5A", dbg_char); end
        checks++;
        if (ac !== 7'h4F) begin failures++; $display("FAIL dec_ac: got %02h expected 4F", ac); end
        bus_write(1'b0, 8'h07, 6, 1);
        bus_write(1'b1, 8'h37, 6, 1);
        dbg_idx = 5'd31; #1;
        checks++;
        if (dbg_char !== 8'h37) begin failures++; $display("FAIL inc_c31: got %02h expected 37", dbg_char); end
        checks++;
        if (ac !== 7'h00) begin failures++; $display("FAIL inc_wrap_ac: got %02h expected 00", ac); end
    endtask

    task automatic test_shift_and_addr();
        bus_write(1'b0, 8'h8F, 6, 1);
        bus_write(1'b0, 8'h14, 6, 1);
        checks++;
        if (ac !== 7'h40) begin failures++; $display("FAIL shift_right_ac: got %02h expected 40", ac); end
        bus_write(1'b0, 8'h10, 6, 1);
        bus_write(1'b0, 8'h1C, 6, 1);
        checks++;
        if (ac !== 7'h0F) begin failures++; $display("FAIL shift_left_ac: got %02h expected 0F", ac); end
        checks++;
        if (err_addr !== 1'b0) begin failures++; $display("FAIL addr_err_early: got %b expected 0", err_addr); end
        bus_write(1'b0, 8'h90, 6, 1);
        checks++;
        if ({err_addr, ac} !== {1'b1, 7'h0F}) begin
            failures++;
            $display("FAIL addr_err: err_addr/ac=%b/%02h expected 1/0F", err_addr, ac);
        end
        bus_write(1'b0, 8'h02, 6, 1);
        checks++;
        if (ac !== 7'h00) begin failures++; $display("FAIL home_ac: got %02h expected 00", ac); end
    endtask

    task automatic test_back_to_back();
        int last_busy;
        bus_write(1'b1, 8'h61, 0, 0);
        repeat (10) @(negedge clk);
        bus_write(1'b1, 8'h62, 0, 0);
        last_busy = 0;
        for (int n = 1; n <= BUSY_CYC + 20; n++) begin
            @(negedge clk);
            if (busy) last_busy = n;
        end
`ifdef LCD_RESP_BUSY_MODEL_EN
        checks++;
        if (err_busy !== 1'b1) begin failures++; $display("FAIL b2b_err_busy: got %b expected 1", err_busy); end
        checks++;
        if (last_busy < BUSY_CYC || last_busy > BUSY_CYC + 6) begin
            failures++;
            $display("FAIL b2b_busy_len: busy until cycle %0d expected %0d..%0d", last_busy, BUSY_CYC, BUSY_CYC + 6);
        end
`else
        checks++;
        if (err_busy !== 1'b0) begin failures++; $display("FAIL b2b_err_busy: got %b expected 0", err_busy); end
        checks++;
        if (last_busy != 0) begin failures++; $display("FAIL b2b_busy_len: busy seen at cycle %0d expected never", last_busy); end
`endif
        dbg_idx = 5'd1; #1;
        checks++;
        if (dbg_char !== 8'h62) begin failures++; $display("FAIL b2b_c1: got %02h expected 62", dbg_char); end
        checks++;
        if (ac !== 7'h02) begin failures++; $display("FAIL b2b_ac: got %02h expected 02", ac); end
    endtask

    task automatic test_clear_reset();
        bus_write(1'b0, 8'h0F, 6, 1);
        bus_write(1'b0, 8'h80, 6, 1);
        for (int i = 0; i < 32; i++) bus_write(1'b1, 8'(8'h30 + i), 6, 1);
        for (int i = 0; i < 32; i++) begin
            dbg_idx = 5'(i); #1;
            checks++;
            if (dbg_char !== 8'(8'h30 + i)) begin
                failures++;
                $display("FAIL fill[%0d]: got %02h expected %02h", i, dbg_char, 8'(8'h30 + i));
            end
        end
        bus_write(1'b0, 8'h01, 13, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, ac, disp_on, cursor_on, blink_on, err_busy, err_addr} !== 13'h0) begin
            failures++;
            $display("FAIL clr_rst_state: busy/ac/flags/errs=%04h expected 0000",
                     {busy, ac, disp_on, cursor_on, blink_on, err_busy, err_addr});
        end
        for (int i = 0; i < 32; i++) begin
            dbg_idx = 5'(i); #1;
            checks++;
            if (dbg_char !== 8'h20) begin
                failures++;
                $display("FAIL clr_rst_ddram[%0d]: got %02h expected 20", i, dbg_char);
            end
        end
    endtask

    task automatic test_clear_full();
        int last_busy;
        bus_write(1'b0, 8'h0F, 6, 1);
        for (int i = 0; i < 4; i++) bus_write(1'b1, 8'(8'h70 + i), 6, 1);
        bus_write(1'b0, 8'h01, 0, 0);
        last_busy = 0;
        for (int n = 1; n <= CLEAR_CYC + 20; n++) begin
            @(negedge clk);
            if (busy) last_busy = n;
            if (n == 40) begin
                for (int i = 0; i < 32; i++) begin
                    dbg_idx = 5'(i); #1;
                    checks++;
                    if (dbg_char !== 8'h20) begin
                        failures++;
                        $display("FAIL clear_ddram[%0d]: got %02h expected 20", i, dbg_char);
                    end
                end
                checks++;
                if (ac !== 7'h00) begin failures++; $display("FAIL clear_ac: got %02h expected 00", ac); end
            end
        end
`ifdef LCD_RESP_BUSY_MODEL_EN
        checks++;
        if (last_busy < CLEAR_CYC || last_busy > CLEAR_CYC + 8) begin
            failures++;
            $display("FAIL clear_busy_len: busy until cycle %0d expected %0d..%0d", last_busy, CLEAR_CYC, CLEAR_CYC + 8);
        end
`else
        checks++;
        if (last_busy != 0) begin failures++; $display("FAIL clear_busy_len: busy seen at cycle %0d expected never", last_busy); end
`endif
        checks++;
        if ({disp_on, err_busy} !== 2'b10) begin
            failures++;
            $display("FAIL clear_keep_flags: disp_on/err_busy=%b expected 10", {disp_on, err_busy});
        end
    endtask

    task automatic test_clear_queue();
        logic [7:0] exp_c0;
        logic [6:0] exp_ac;
        logic       exp_err;
`ifdef LCD_RESP_BUSY_MODEL_EN
        exp_c0 = 8'h20; exp_ac = 7'h00; exp_err = 1'b1;
`else
        exp_c0 = 8'h55; exp_ac = 7'h01; exp_err = 1'b0;
`endif
        bus_write(1'b0, 8'h01, 0, 0);
        bus_write(1'b1, 8'h55, 0, 0);
        bus_write(1'b1, 8'h66, 0, 0);
        repeat (CLEAR_CYC + 20) @(negedge clk);
        dbg_idx = 5'd0; #1;
        checks++;
        if (dbg_char !== exp_c0) begin failures++; $display("FAIL queue_c0: got %02h expected %02h", dbg_char, exp_c0); end
        dbg_idx = 5'd1; #1;
        checks++;
        if (dbg_char !== 8'h20) begin failures++; $display("FAIL queue_c1: got %02h expected 20", dbg_char); end
        checks++;
        if (ac !== exp_ac) begin failures++; $display("FAIL queue_ac: got %02h expected %02h", ac, exp_ac); end
        checks++;
        if (err_busy !== exp_err) begin failures++; $display("FAIL queue_err_busy: got %b expected %b", err_busy, exp_err); end
    endtask

    initial begin
        test_reset();
        test_display();
        test_wrap();
        test_decrement();
        test_shift_and_addr();
        test_back_to_back();
        test_clear_reset();
        test_clear_full();
        test_clear_queue();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL read_missing: %0d expected reads never seen", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
